if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue_pkg.sv | 28 ++
 rtl/if_id_queue_gen_pipe_dff.sv | 25 ++
 rtl/if_id_queue.sv | 104 ++++++++++
 tb/tb_if_id_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared core definitions for the fetch/decode boundary: reset values,
// hold levels and bus widths used across the pipeline.
package if_id_queue_pkg;

  // Bus widths
  localparam int INST_W        = 32;
  localparam int INT_BUS_W     = 8;
  localparam int HOLD_FLAG_W   = 3;

  // Reset / idle values
  localparam logic [INST_W-1:0]    INST_NOP = 32'h0000_0001;
  localparam logic [INST_W-1:0]    ZeroWord = 32'h0000_0000;
  localparam logic [INT_BUS_W-1:0] INT_NONE = 8'h00;

  // Pipeline hold levels; a stage is held when the flag is at or above its level.
  typedef enum logic [HOLD_FLAG_W-1:0] {
    Hold_None = 3'd0,
    Hold_Pc   = 3'd1,
    Hold_If   = 3'd2,
    Hold_Id   = 3'd3
  } hold_flag_e;

  // True when the requested hold level stalls the IF/ID boundary.
  function automatic logic hold_reaches_if(input logic [HOLD_FLAG_W-1:0] flag);
    return flag >= HOLD_FLAG_W'(Hold_If);
  endfunction

endpackage

// File: rtl/if_id_queue_gen_pipe_dff.sv
// Generic pipeline register: loads din every cycle, holds its value while
// hold_en is high, and returns to def_val on asynchronous reset.
module gen_pipe_dff #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold_en,
  input  logic [DW-1:0] def_val,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] qout
);

  // Pipeline register with hold and asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qout <= def_val;
    end else if (!hold_en) begin
      qout <= din;
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode. Decouples the fetch stream
// from decode back-pressure, flushes on jump/trap, and registers the
// interrupt flags alongside the pipeline hold.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4,
  parameter int IW    = INT_BUS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            inst_i,
  input  logic [AW-1:0]            inst_addr_i,
  input  logic                     inst_valid_i,
  output logic                     inst_ready_o,
  input  logic [HOLD_FLAG_W-1:0]   hold_flag_i,
  input  logic                     flush_i,
  input  logic [IW-1:0]            int_flag_i,
  input  logic                     id_ready_i,
  output logic [DW-1:0]            inst_o,
  output logic [AW-1:0]            inst_addr_o,
  output logic                     inst_valid_o,
  output logic [IW-1:0]            int_flag_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage and bookkeeping
  logic [DW-1:0]    r_mem_inst [DEPTH];
  logic [AW-1:0]    r_mem_addr [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_hold_en;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_hold_en = hold_reaches_if(hold_flag_i);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);

  // Flush drops ready so nothing is written in the cycle the queue is discarded.
  assign inst_ready_o = !w_full && !flush_i;
  assign w_push       = inst_valid_i && inst_ready_o;
  // inst_valid_o gates pop, so an empty queue never pops even with a push pending.
  assign w_pop        = inst_valid_o && id_ready_i && !w_hold_en && !flush_i;

  // Write the incoming entry at the tail; pointers wrap naturally at DEPTH.
  // NOTE: storage has no reset on purpose; an entry is only read while
  // count says it was written, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= inst_i;
      r_mem_addr[r_wr_ptr] <= inst_addr_i;
    end
  end

  // Pointer and occupancy tracking; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation: registered storage only, so a push shows up a cycle later.
  assign inst_valid_o = !w_empty;
  assign inst_o       = w_empty ? DW'(INST_NOP) : r_mem_inst[r_rd_ptr];
  assign inst_addr_o  = w_empty ? AW'(ZeroWord) : r_mem_addr[r_rd_ptr];
  assign level_o      = r_count;

  // Interrupt flags follow the pipeline hold but ignore flush.
  gen_pipe_dff #(
    .DW(IW)
  ) u_int_flag_dff (
    .clk     (clk),
    .rst     (rst),
    .hold_en (w_hold_en),
    .def_val (IW'(INT_NONE)),
    .din     (int_flag_i),
    .qout    (int_flag_o)
  );

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue at DEPTH=4.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [2:0]  hold_flag_i;
  logic        flush_i;
  logic [7:0]  int_flag_i;
  logic        id_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic [7:0]  int_flag_o;
  logic [2:0]  level_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP_EXP = 32'h0000_0001;

  logic [31:0] fill_data [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

  if_id_queue #(.DW(32), .AW(32), .DEPTH(4), .IW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .inst_valid_i (inst_valid_i),
    .inst_ready_o (inst_ready_o),
    .hold_flag_i  (hold_flag_i),
    .flush_i      (flush_i),
    .int_flag_i   (int_flag_i),
    .id_ready_i   (id_ready_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .int_flag_o   (int_flag_o),
    .level_o      (level_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; inst_i = '0; inst_addr_i = '0; inst_valid_i = 1'b0;
    hold_flag_i = 3'd0; flush_i = 1'b0; int_flag_i = '0; id_ready_i = 1'b0;
    #3;
    checks++; if (level_o !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level_o); end
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid_o); end
    checks++; if (inst_o !== NOP_EXP) begin failures++; $display("FAIL reset_inst got=%h exp=%h", inst_o, NOP_EXP); end
    checks++; if (inst_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", inst_addr_o); end
    checks++; if (int_flag_o !== 8'h00) begin failures++; $display("FAIL reset_int got=%h exp=00", int_flag_o); end
    checks++; if (inst_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", inst_ready_o); end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      inst_i = fill_data[i]; inst_addr_i = 32'(i * 4); inst_valid_i = 1'b1; id_ready_i = 1'b0;
      step();
      checks++; if (level_o !== 3'(i + 1)) begin failures++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level_o, i + 1); end
    end
    inst_valid_i = 1'b0;
    checks++; if (inst_ready_o !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", inst_ready_o); end
    checks++; if (inst_o !== 32'h0000_0013) begin failures++; $display("FAIL fill_head got=%h exp=00000013", inst_o); end
    checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL fill_valid got=%b exp=1", inst_valid_o); end
    // Push while full must be refused.
    inst_i = 32'hDEAD_BEEF; inst_addr_i = 32'h40; inst_valid_i = 1'b1;
    step();
    inst_valid_i = 1'b0;
    checks++; if (level_o !== 3'd4) begin failures++; $display("FAIL full_push_level got=%0d exp=4", level_o); end
    checks++; if (inst_o !== 32'h0000_0013) begin failures++; $display("FAIL full_push_head got=%h exp=00000013", inst_o); end
  endtask

  task automatic test_drain();
    id_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (inst_addr_o !== 32'(i * 4)) begin failures++; $display("FAIL drain_addr[%0d] got=%h exp=%h", i, inst_addr_o, i * 4); end
      checks++; if (inst_o !== fill_data[i]) begin failures++; $display("FAIL drain_inst[%0d] got=%h exp=%h", i, inst_o, fill_data[i]); end
      step();
    end
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", inst_valid_o); end
    checks++; if (inst_o !== NOP_EXP) begin failures++; $display("FAIL drain_nop got=%h exp=%h", inst_o, NOP_EXP); end
    checks++; if (inst_addr_o !== 32'h0) begin failures++; $display("FAIL drain_addr_zero got=%h exp=0", inst_addr_o); end
    step();
    checks++; if (level_o !== 3'd0) begin failures++; $display("FAIL empty_pop_level got=%0d exp=0", level_o); end
    id_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Push into empty queue with decode ready: entry must stay, not pop.
    inst_i = 32'hA000_0000; inst_addr_i = 32'h0; inst_valid_i = 1'b1; id_ready_i = 1'b1;
    step();
    checks++; if (level_o !== 3'd1) begin failures++; $display("FAIL empty_push_level got=%0d exp=1", level_o); end
    inst_i = 32'hA000_0001; inst_addr_i = 32'h4; id_ready_i = 1'b0;
    step();
    checks++; if (level_o !== 3'd2) begin failures++; $display("FAIL pp_prefill_level got=%0d exp=2", level_o); end
    id_ready_i = 1'b1;
    for (int n = 2; n < 14; n++) begin
      inst_i = 32'hA000_0000 + 32'(n); inst_addr_i = 32'(n * 4); inst_valid_i = 1'b1;
      checks++; if (inst_o !== 32'hA000_0000 + 32'(n - 2)) begin failures++; $display("FAIL pp_head[%0d] got=%h exp=%h", n, inst_o, 32'hA000_0000 + 32'(n - 2)); end
      checks++; if (inst_addr_o !== 32'((n - 2) * 4)) begin failures++; $display("FAIL pp_addr[%0d] got=%h exp=%h", n, inst_addr_o, (n - 2) * 4); end
      step();
      checks++; if (level_o !== 3'd2) begin failures++; $display("FAIL pp_level[%0d] got=%0d exp=2", n, level_o); end
    end
    inst_valid_i = 1'b0; id_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    int_flag_i = 8'h5A;
    inst_i = 32'hA000_000E; inst_addr_i = 32'h38; inst_valid_i = 1'b1;
    step();
    checks++; if (level_o !== 3'd3) begin failures++; $display("FAIL flush_pre_level got=%0d exp=3", level_o); end
    checks++; if (int_flag_o !== 8'h5A) begin failures++; $display("FAIL flush_pre_int got=%h exp=5a", int_flag_o); end
    inst_i = 32'hBBBB_BBBB; inst_addr_i = 32'h3C; inst_valid_i = 1'b1; id_ready_i = 1'b1; flush_i = 1'b1;
    #1;
    checks++; if (inst_ready_o !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", inst_ready_o); end
    step();
    flush_i = 1'b0; inst_valid_i = 1'b0; id_ready_i = 1'b0;
    checks++; if (level_o !== 3'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level_o); end
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", inst_valid_o); end
    checks++; if (int_flag_o !== 8'h5A) begin failures++; $display("FAIL flush_int got=%h exp=5a", int_flag_o); end
    // Queue must be usable right after flush.
    inst_i = 32'hCAFE_0001; inst_addr_i = 32'h200; inst_valid_i = 1'b1;
    step();
    inst_valid_i = 1'b0;
    checks++; if (inst_o !== 32'hCAFE_0001) begin failures++; $display("FAIL post_flush_head got=%h exp=cafe0001", inst_o); end
    id_ready_i = 1'b1;
    step();
    id_ready_i = 1'b0;
    checks++; if (level_o !== 3'd0) begin failures++; $display("FAIL post_flush_pop got=%0d exp=0", level_o); end
  endtask

  task automatic test_hold();
    logic [31:0] h_inst [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    int_flag_i = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      inst_i = h_inst[i]; inst_addr_i = 32'h100 + 32'(i * 4); inst_valid_i = 1'b1;
      step();
    end
    inst_valid_i = 1'b0;
    checks++; if (int_flag_o !== 8'h3C) begin failures++; $display("FAIL hold_pre_int got=%h exp=3c", int_flag_o); end
    hold_flag_i = 3'(Hold_If); id_ready_i = 1'b1; int_flag_i = 8'hC3;
    for (int c = 0; c < 3; c++) begin
      inst_valid_i = (c < 2);
      inst_i = h_inst[2 + (c % 2)]; inst_addr_i = 32'h108 + 32'((c % 2) * 4);
      step();
      checks++; if (inst_o !== h_inst[0]) begin failures++; $display("FAIL hold_head[%0d] got=%h exp=%h", c, inst_o, h_inst[0]); end
      checks++; if (level_o !== 3'((c < 2) ? 3 + c : 4)) begin failures++; $display("FAIL hold_level[%0d] got=%0d exp=%0d", c, level_o, (c < 2) ? 3 + c : 4); end
      checks++; if (int_flag_o !== 8'h3C) begin failures++; $display("FAIL hold_int[%0d] got=%h exp=3c", c, int_flag_o); end
    end
    inst_valid_i = 1'b0;
    hold_flag_i = 3'(Hold_Id);
    step();
    checks++; if (level_o !== 3'd4) begin failures++; $display("FAIL hold_id_level got=%0d exp=4", level_o); end
    // Hold_Pc is below the IF level: queue drains in order and flags resume.
    hold_flag_i = 3'(Hold_Pc);
    for (int i = 0; i < 4; i++) begin
      checks++; if (inst_o !== h_inst[i]) begin failures++; $display("FAIL hold_release_head[%0d] got=%h exp=%h", i, inst_o, h_inst[i]); end
      step();
    end
    checks++; if (level_o !== 3'd0) begin failures++; $display("FAIL hold_release_level got=%0d exp=0", level_o); end
    checks++; if (int_flag_o !== 8'hC3) begin failures++; $display("FAIL hold_release_int got=%h exp=c3", int_flag_o); end
    hold_flag_i = 3'(Hold_None); id_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int_flag_i = 8'h77;
    for (int i = 0; i < 2; i++) begin
      inst_i = 32'h5555_0000 + 32'(i); inst_addr_i = 32'h300 + 32'(i * 4); inst_valid_i = 1'b1;
      step();
    end
    inst_valid_i = 1'b0;
    checks++; if (level_o !== 3'd2) begin failures++; $display("FAIL rmid_pre_level got=%0d exp=2", level_o); end
    checks++; if (int_flag_o !== 8'h77) begin failures++; $display("FAIL rmid_pre_int got=%h exp=77", int_flag_o); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (level_o !== 3'd0) begin failures++; $display("FAIL rmid_level got=%0d exp=0", level_o); end
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", inst_valid_o); end
    checks++; if (inst_o !== NOP_EXP) begin failures++; $display("FAIL rmid_inst got=%h exp=%h", inst_o, NOP_EXP); end
    checks++; if (inst_addr_o !== 32'h0) begin failures++; $display("FAIL rmid_addr got=%h exp=0", inst_addr_o); end
    checks++; if (int_flag_o !== 8'h00) begin failures++; $display("FAIL rmid_int got=%h exp=00", int_flag_o); end
    step();
    rst = 1'b1;
    int_flag_i = 8'h00;
    step();
    checks++; if (level_o !== 3'd0) begin failures++; $display("FAIL rmid_after_level got=%0d exp=0", level_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
